// File: rtl/down_counter_sched4.sv
// down_counter_sched4: one shared down-counter lent to one of four requesters at a time.
// Arbitration is round-robin by default; define DOWN_SCHED_FIXED_PRIO_EN for lowest-index-wins.
module down_counter_sched4 #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                  clock0,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_value,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       done,
    output logic                  abort
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic {S_IDLE, S_COUNT} state_t;

    state_t           r_state, w_state;
    logic [NREQ-1:0]  r_gnt, w_gnt, r_done, w_done;
    logic [WIDTH-1:0] r_count, w_count;
    logic             r_abort, w_abort;
    logic [PW-1:0]    w_base, w_win;
    logic             w_owner_req;

`ifdef DOWN_SCHED_FIXED_PRIO_EN
    assign w_base = '0;
`else
    logic [PW-1:0] r_ptr;
    assign w_base = r_ptr;
    // Round-robin pointer moves to the slot just past each new winner
    always_ff @(posedge clock0 or negedge reset)
        if (!reset)
            r_ptr <= '0;
        else if (r_state == S_IDLE && |req)
            r_ptr <= w_win + PW'(1);
`endif

    // Winner is the first set req bit searching upward from w_base with wrap-around
    always_comb begin
        w_win = w_base;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[w_base + PW'(k)]) w_win = w_base + PW'(k);
    end

    assign w_owner_req = |(req & r_gnt);

    // State register; reset abandons any countdown without a done or abort pulse
    always_ff @(posedge clock0 or negedge reset)
        if (!reset) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_count <= '0;
            r_done  <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state;
            r_gnt   <= w_gnt;
            r_count <= w_count;
            r_done  <= w_done;
            r_abort <= w_abort;
        end

    // Next state: grant from IDLE; in COUNT an owner drop beats completion, which beats decrement
    always_comb begin
        w_state = r_state;
        w_gnt   = r_gnt;
        w_count = r_count;
        w_done  = '0;
        w_abort = 1'b0;
        if (r_state == S_IDLE) begin
            if (|req) begin
                w_state = S_COUNT;
                w_gnt   = NREQ'(1) << w_win;
                w_count = req_value[int'(w_win)*WIDTH +: WIDTH];
            end
        end else if (!w_owner_req) begin
            w_state = S_IDLE;
            w_gnt   = '0;
            w_abort = 1'b1;
        end else if (r_count == '0) begin
            w_state = S_IDLE;
            w_gnt   = '0;
            w_done  = r_gnt;
        end else begin
            w_count = r_count - WIDTH'(1);
        end
    end

    // Outputs are driven straight from registered state
    always_comb begin
        busy  = (r_state == S_COUNT);
        gnt   = r_gnt;
        count = r_count;
        done  = r_done;
        abort = r_abort;
    end
endmodule

// File: tb/tb_down_counter_sched4.sv
// tb_down_counter_sched4: directed scenarios plus random traffic against a behavioural model.
module tb_down_counter_sched4;
    logic        clock0 = 1'b0;
    logic        reset;
    logic [3:0]  req = '0;
    logic [63:0] req_value = '0;
    logic [3:0]  gnt, done;
    logic        busy, abort;
    logic [15:0] count;

    down_counter_sched4 #(.WIDTH(16), .NREQ(4)) dut (
        .clock0(clock0), .reset(reset), .req(req), .req_value(req_value),
        .gnt(gnt), .busy(busy), .count(count), .done(done), .abort(abort)
    );

    always #5 clock0 = ~clock0;

    int checks = 0;
    int errors = 0;

    int          mowner = -1;
    logic [15:0] mcount = '0;
    int          mptr = 0;
    logic [3:0]  mdone = '0;
    logic        mabort = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] slice(input int i);
        return req_value[i*16 +: 16];
    endfunction

    // Model: one owner index at a time, its remaining count, and the rotation pointer
    initial forever begin
        @(posedge clock0 or negedge reset);
        if (!reset) begin
            mowner = -1; mcount = '0; mptr = 0; mdone = '0; mabort = 1'b0;
        end else begin
            int base, w;
            mdone = '0;
            mabort = 1'b0;
            if (mowner < 0) begin
                if (req != 0) begin
`ifdef DOWN_SCHED_FIXED_PRIO_EN
                    base = 0;
`else
                    base = mptr;
`endif
                    w = -1;
                    for (int k = 0; k < 4; k++)
                        if (w < 0 && req[(base + k) % 4]) w = (base + k) % 4;
                    mowner = w;
                    mcount = slice(w);
                    mptr = (w + 1) % 4;
                end
            end else if (!req[mowner]) begin
                mabort = 1'b1;
                mowner = -1;
            end else if (mcount == 0) begin
                mdone[mowner] = 1'b1;
                mowner = -1;
            end else begin
                mcount = mcount - 16'd1;
            end
        end
        #1;
        begin
            logic [3:0] eg;
            eg = (mowner < 0) ? 4'b0 : 4'(1 << mowner);
            checks++;
            if ({gnt, busy, count, done, abort} !== {eg, mowner >= 0, mcount, mdone, mabort}) begin
                errors++;
                $display("FAIL model gnt/busy/count/done/abort got %h/%b/%h/%h/%b expected %h/%b/%h/%h/%b at %0t",
                         gnt, busy, count, done, abort, eg, mowner >= 0, mcount, mdone, mabort, $time);
            end
        end
    end

    task automatic edge_();
        @(posedge clock0);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        edge_();
        reset = 1'b1;
    endtask

    int order[$];
    int rr_exp[5];
    int exp2;

    initial begin
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_abort", 32'(abort), 32'h0);
        edge_();
        reset = 1'b1;

        // Single request, load 3
        req_value[16 +: 16] = 16'd3;
        req = 4'b0010;
        edge_();
        chk("s1_gnt", 32'(gnt), 32'h2);
        chk("s1_count0", 32'(count), 32'd3);
        for (int k = 1; k <= 3; k++) begin
            edge_();
            chk("s1_count", 32'(count), 32'(3 - k));
        end
        edge_();
        chk("s1_done", 32'(done), 32'h2);
        chk("s1_busy", 32'(busy), 32'h0);
        req = 4'b0000;
        edge_();
        chk("s1_done_clr", 32'(done), 32'h0);

        // Zero load
        req_value[15:0] = 16'd0;
        req = 4'b0001;
        edge_();
        chk("s2_gnt", 32'(gnt), 32'h1);
        edge_();
        chk("s2_done", 32'(done), 32'h1);
        chk("s2_count", 32'(count), 32'h0);
        req = 4'b0000;
        edge_();

        // Round-robin order with all requesters held
        do_reset();
        req_value = {16'd1, 16'd1, 16'd1, 16'd1};
        req = 4'b1111;
        begin
            logic pb;
            pb = 1'b0;
            for (int c = 0; c < 40 && order.size() < 5; c++) begin
                edge_();
                if (busy && !pb)
                    for (int i = 0; i < 4; i++) if (gnt[i]) order.push_back(i);
                pb = busy;
            end
        end
`ifdef DOWN_SCHED_FIXED_PRIO_EN
        rr_exp = '{0, 0, 0, 0, 0};
`else
        rr_exp = '{0, 1, 2, 3, 0};
`endif
        chk("rr_grants", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < order.size()) chk("rr_order", 32'(order[i]), 32'(rr_exp[i]));
        req = 4'b0000;
        repeat (3) edge_();

        // Abort after four decrements
        req_value[32 +: 16] = 16'd10;
        req = 4'b0100;
        edge_();
        chk("s4_gnt", 32'(gnt), 32'h4);
        chk("s4_count0", 32'(count), 32'd10);
        repeat (4) edge_();
        chk("s4_count6", 32'(count), 32'd6);
        req = 4'b0000;
        edge_();
        chk("s4_abort", 32'(abort), 32'h1);
        chk("s4_nodone", 32'(done), 32'h0);
        chk("s4_hold", 32'(count), 32'd6);
        chk("s4_gnt0", 32'(gnt), 32'h0);
        edge_();
        chk("s4_abort_clr", 32'(abort), 32'h0);
        chk("s4_idle_hold", 32'(count), 32'd6);

        // Reset in the middle of a long countdown
        req_value[48 +: 16] = 16'hFFFF;
        req = 4'b1000;
        edge_();
        chk("s5_gnt", 32'(gnt), 32'h8);
        repeat (100) edge_();
        chk("s5_count", 32'(count), 32'(16'hFFFF - 16'd100));
        reset = 1'b0;
        #1;
        chk("s5_count_rst", 32'(count), 32'h0);
        chk("s5_gnt_rst", 32'(gnt), 32'h0);
        chk("s5_busy_rst", 32'(busy), 32'h0);
        chk("s5_done_rst", 32'(done), 32'h0);
        chk("s5_abort_rst", 32'(abort), 32'h0);
        edge_();
        req = 4'b0000;
        reset = 1'b1;
        edge_();
        chk("s5_after_done", 32'(done), 32'h0);
        chk("s5_after_abort", 32'(abort), 32'h0);

        // Back-to-back requesters 0 and 1
        do_reset();
        req_value[31:0] = {16'd2, 16'd2};
        req = 4'b0011;
`ifdef DOWN_SCHED_FIXED_PRIO_EN
        exp2 = 1;
`else
        exp2 = 2;
`endif
        edge_();
        chk("s6_gnt0", 32'(gnt), 32'h1);
        chk("s6_count0", 32'(count), 32'd2);
        repeat (2) edge_();
        edge_();
        chk("s6_done0", 32'(done), 32'h1);
        chk("s6_idle", 32'(busy), 32'h0);
        edge_();
        chk("s6_gnt1", 32'(gnt), 32'(exp2));
        repeat (2) edge_();
        edge_();
        chk("s6_done1", 32'(done), 32'(exp2));
        req = 4'b0000;
        repeat (2) edge_();

        // Random traffic, including value changes mid-count and occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                edge_();
                reset = 1'b1;
            end else begin
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 3) == 0)
                    req_value[$urandom_range(0, 3)*16 +: 16] = 16'($urandom_range(0, 6));
                edge_();
            end
        end
        req = 4'b0000;
        edge_();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/down_counter_sched4.md
DOWN_COUNTER_SCHED4 -- requirements
Module: down_counter_sched4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, counter and load-value width.
REQ-002 The block SHALL have parameter NREQ, default 4, number of requesters; only 4 is supported.
REQ-003 The block SHALL have port clock0, input, 1, rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, NREQ, per-requester countdown request, level, held until done.
REQ-006 The block SHALL have port req_value, input, NREQ*WIDTH, per-requester load value; slice i is bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-007 The block SHALL have port gnt, output, NREQ, one-hot owner of the shared counter.
REQ-008 The block SHALL have port busy, output, 1, high while the counter is owned.
REQ-009 The block SHALL have port count, output, WIDTH, shared down-counter value.
REQ-010 The block SHALL have port done, output, NREQ, one-cycle completion pulse to the owner.
REQ-011 The block SHALL have port abort, output, 1, one-cycle pulse when the owner drops req early.

Function
REQ-012 The block SHALL implement two states: IDLE (gnt=0, busy=0) and COUNT (one gnt bit high, busy=1).
REQ-013 In IDLE with any req bit high at a clock edge, the block SHALL select a winner i, enter COUNT, set gnt[i]=1, load count with req_value slice i, and set ptr to (i+1) mod NREQ, all at that edge.
REQ-014 Winner selection SHALL be round-robin: the first set req bit searching upward from ptr with wrap-around.
REQ-015 In COUNT with count!=0 and req[i] high, count SHALL decrement by 1 per edge.
REQ-016 In COUNT with count==0 and req[i] high, the block SHALL at that edge enter IDLE, clear gnt, and pulse done[i] for one cycle; count SHALL hold 0.
REQ-017 done[i] SHALL follow the grant edge by exactly req_value+1 edges; load value 0 gives done one edge after grant.
REQ-018 In COUNT with req[i] low at an edge, the block SHALL enter IDLE, clear gnt, pulse abort for one cycle, and not assert done; count SHALL hold its value.
REQ-019 Abort SHALL take precedence over completion when both apply at the same edge.
REQ-020 After done or abort, at least one IDLE cycle SHALL elapse before the next grant.
REQ-021 req bits of non-owners and changes to req_value after loading SHALL have no effect during COUNT.
REQ-022 count SHALL never wrap below 0; in IDLE it SHALL hold its last value.
REQ-023 At most one bit of gnt and done SHALL ever be high; done and abort SHALL never be high together.

Reset
REQ-024 While reset is low, the block SHALL force state=IDLE, gnt=0, busy=0, count=0, done=0, abort=0, ptr=0, independent of clock0.
REQ-025 Reset asserted during COUNT SHALL abandon the countdown without a done or abort pulse.
REQ-026 After reset deasserts, the first grant SHALL occur at the first rising edge with a req bit high.

Configuration
REQ-027 The macro DOWN_SCHED_FIXED_PRIO_EN SHALL select the arbitration policy.
REQ-028 With DOWN_SCHED_FIXED_PRIO_EN defined, the block SHALL select the lowest-index set req bit, and ptr SHALL be unused.
REQ-029 Without DOWN_SCHED_FIXED_PRIO_EN, the block SHALL use round-robin per REQ-014.

Verification
REQ-030 Scenario single request: req=4'b0010, slice1=3 -> gnt=0010 after edge E0; count sequence 3,2,1,0; done=0010 for one cycle after E4; then busy=0.
REQ-031 Scenario zero load: req=4'b0001, slice0=0 -> grant at E0, done[0] after E1, count=0.
REQ-032 Scenario round-robin: req=4'b1111 held, all slices=1 -> grant order 0,1,2,3,0; with DOWN_SCHED_FIXED_PRIO_EN -> always 0.
REQ-033 Scenario abort: req[2] with slice2=10, req[2] dropped after 4 decrements -> abort pulses, no done, count holds 6, gnt=0.
REQ-034 Scenario reset mid-count: slice3=16'hFFFF granted, reset low after 100 cycles -> count=0, gnt=0, busy=0 immediately, no done or abort.
REQ-035 Scenario back-to-back: req[0] and req[1] held, slices=2 -> done[0], one IDLE cycle, gnt=0010, done[1] three edges after its grant.
